// File: rtl/ctrl_bubble_stage_pkg.sv
// ctrl_pkg: control-bundle layout shared by the
// ID/EX bubble stage, its interface and its bench.
package ctrl_pkg;

    localparam int CTRL_W       = 9;
    localparam int REGDST_BIT   = 8;
    localparam int REGWRITE_BIT = 7;
    localparam int ALUSRC_BIT   = 6;
    localparam int MEMREAD_BIT  = 5;
    localparam int MEMWRITE_BIT = 4;
    localparam int MEMTOREG_BIT = 3;
    localparam int ALUOP_LSB    = 0;
    localparam int ALUOP_W      = 3;

    typedef struct packed {
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ctrl_bubble_stage_if.sv
// ctrl_bubble_stage_if: ID-side inputs and EX-side
// outputs of the control bubble stage.
interface ctrl_bubble_stage_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 3
);
    import ctrl_pkg::*;

    logic [CTRL_W-1:0] id_ctrl;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_dst;
    logic              flush;
    logic              ext_stall;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_dst;
    logic              stall_if_id;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [15:0]       bubbles_total;

    modport master (
        output id_ctrl, id_valid, id_rs, id_rt, id_uses_rt, id_dst,
        output flush, ext_stall,
        input  ex_ctrl, ex_valid, ex_dst, stall_if_id,
        input  bubble_cnt, bubbles_total
    );

    modport slave (
        input  id_ctrl, id_valid, id_rs, id_rt, id_uses_rt, id_dst,
        input  flush, ext_stall,
        output ex_ctrl, ex_valid, ex_dst, stall_if_id,
        output bubble_cnt, bubbles_total
    );

endinterface

// File: rtl/ctrl_bubble_stage_hazard.sv
// hazard_detect: load-use check between the load in EX
// and the sources of the instruction in ID.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              cnt_idle,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              hazard
);

    logic rs_hit;
    logic rt_hit;
    logic ex_load;

    // r0 is hardwired, so a load into it never blocks
    assign ex_load = ex_valid & ex_mem_read & (ex_dst != '0);
    assign rs_hit  = (ex_dst == id_rs);
    assign rt_hit  = id_uses_rt & (ex_dst == id_rt);
    assign hazard  = cnt_idle & ex_load & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage: ID/EX control register with load-use
// bubble insertion, flush, freeze and a bubble counter.
module ctrl_bubble_stage
    import ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 3
) (
    input logic                clk,
    input logic                rst,
    ctrl_bubble_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_t             ex_ctrl_q;
    ctrl_t             ex_ctrl_d;
    logic              ex_valid_q;
    logic              ex_valid_d;
    logic [REG_AW-1:0] ex_dst_q;
    logic [REG_AW-1:0] ex_dst_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [15:0]       total_q;
    logic [15:0]       total_d;
    logic              cnt_idle;
    logic              hazard;
    ctrl_t             id_ctrl_g;

    assign cnt_idle  = (cnt_q == '0);
    assign id_ctrl_g = bus.id_valid ? ctrl_t'(bus.id_ctrl) : CTRL_NOP;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .cnt_idle    (cnt_idle),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q[MEMREAD_BIT]),
        .ex_dst      (ex_dst_q),
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .hazard      (hazard)
    );

    // next state: freeze, flush, countdown, hazard, then normal advance
    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_valid_d = ex_valid_q;
        ex_dst_d   = ex_dst_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        if (bus.ext_stall) begin
            cnt_d = cnt_q;
        end else if (bus.flush) begin
            ex_ctrl_d  = CTRL_NOP;
            ex_valid_d = 1'b0;
            ex_dst_d   = '0;
            cnt_d      = '0;
        end else if (!cnt_idle) begin
            ex_ctrl_d  = CTRL_NOP;
            ex_valid_d = 1'b0;
            ex_dst_d   = '0;
            cnt_d      = cnt_q - CNT_ONE;
            total_d    = sat_inc16(total_q);
        end else if (hazard) begin
            ex_ctrl_d  = CTRL_NOP;
            ex_valid_d = 1'b0;
            ex_dst_d   = '0;
            cnt_d      = CNT_LOAD;
            total_d    = sat_inc16(total_q);
        end else begin
            ex_ctrl_d  = id_ctrl_g;
            ex_valid_d = bus.id_valid;
            ex_dst_d   = bus.id_dst;
        end
    end

    // stage registers; reset aborts any countdown at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl_q  <= CTRL_NOP;
            ex_valid_q <= 1'b0;
            ex_dst_q   <= '0;
            cnt_q      <= '0;
            total_q    <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_valid_q <= ex_valid_d;
            ex_dst_q   <= ex_dst_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
        end
    end

    assign bus.ex_ctrl       = ex_ctrl_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_dst        = ex_dst_q;
    assign bus.bubble_cnt    = cnt_q;
    assign bus.bubbles_total = total_q;
    assign bus.stall_if_id   = bus.ext_stall | hazard | !cnt_idle;

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// tb_ctrl_bubble_stage: directed vectors on three stage
// instances (LOAD_STALL = 1, 3 and 7) sharing one stimulus.
module tb_ctrl_bubble_stage;

    localparam logic [8:0] LW  = 9'h0E8;
    localparam logic [8:0] ADD = 9'h182;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    ctrl_bubble_stage_if #(.REG_AW(5), .CNT_W(3)) bus_a ();
    ctrl_bubble_stage_if #(.REG_AW(5), .CNT_W(3)) bus_b ();
    ctrl_bubble_stage_if #(.REG_AW(5), .CNT_W(3)) bus_c ();

    ctrl_bubble_stage #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ctrl_bubble_stage #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    ctrl_bubble_stage #(.REG_AW(5), .LOAD_STALL(7), .CNT_W(3)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic [8:0] c, input logic v,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic [4:0] d);
        bus_a.id_ctrl = c; bus_a.id_valid = v; bus_a.id_rs = rs;
        bus_a.id_rt = rt; bus_a.id_uses_rt = ur; bus_a.id_dst = d;
        bus_b.id_ctrl = c; bus_b.id_valid = v; bus_b.id_rs = rs;
        bus_b.id_rt = rt; bus_b.id_uses_rt = ur; bus_b.id_dst = d;
        bus_c.id_ctrl = c; bus_c.id_valid = v; bus_c.id_rs = rs;
        bus_c.id_rt = rt; bus_c.id_uses_rt = ur; bus_c.id_dst = d;
    endtask

    task automatic set_ctl(input logic f, input logic s);
        bus_a.flush = f; bus_a.ext_stall = s;
        bus_b.flush = f; bus_b.ext_stall = s;
        bus_c.flush = f; bus_c.ext_stall = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_id(9'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        repeat (n) tick();
    endtask

    initial begin
        logic [15:0] prev;
        bit          wrapped;
        bit          hit;

        rst = 1'b1;
        set_ctl(1'b0, 1'b0);
        set_id(9'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        #12;
        chk("rst_ctrl", bus_a.ex_ctrl, 0);
        chk("rst_valid", bus_a.ex_valid, 0);
        chk("rst_dst", bus_a.ex_dst, 0);
        chk("rst_cnt", bus_a.bubble_cnt, 0);
        chk("rst_total", bus_a.bubbles_total, 0);
        chk("rst_stall", bus_a.stall_if_id, 0);
        set_ctl(1'b0, 1'b1);
        #1;
        chk("rst_stall_ext", bus_a.stall_if_id, 1);
        set_ctl(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // load-use, one bubble (instance a)
        set_id(LW, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5);
        tick();
        chk("lu1_ex_ctrl", bus_a.ex_ctrl, LW);
        chk("lu1_ex_dst", bus_a.ex_dst, 5);
        set_id(ADD, 1'b1, 5'd5, 5'd2, 1'b1, 5'd3);
        #1;
        chk("lu1_stall_det", bus_a.stall_if_id, 1);
        tick();
        chk("lu1_bub_valid", bus_a.ex_valid, 0);
        chk("lu1_bub_ctrl", bus_a.ex_ctrl, 0);
        chk("lu1_bub_dst", bus_a.ex_dst, 0);
        chk("lu1_bub_cnt", bus_a.bubble_cnt, 0);
        chk("lu1_total", bus_a.bubbles_total, 1);
        chk("lu1_stall_end", bus_a.stall_if_id, 0);
        tick();
        chk("lu1_add_ctrl", bus_a.ex_ctrl, ADD);
        chk("lu1_add_dst", bus_a.ex_dst, 3);
        chk("lu1_add_valid", bus_a.ex_valid, 1);
        idle(4);
        chk("lu1_b_total", bus_b.bubbles_total, 3);

        // load-use via rt, three bubbles (instance b)
        set_id(LW, 1'b1, 5'd0, 5'd0, 1'b0, 5'd7);
        tick();
        chk("lu3_ex_dst", bus_b.ex_dst, 7);
        set_id(ADD, 1'b1, 5'd1, 5'd7, 1'b1, 5'd4);
        #1;
        chk("lu3_stall_det", bus_b.stall_if_id, 1);
        tick();
        chk("lu3_cnt2", bus_b.bubble_cnt, 2);
        chk("lu3_tot4", bus_b.bubbles_total, 4);
        chk("lu3_stall2", bus_b.stall_if_id, 1);
        chk("lu3_valid2", bus_b.ex_valid, 0);
        tick();
        chk("lu3_cnt1", bus_b.bubble_cnt, 1);
        chk("lu3_tot5", bus_b.bubbles_total, 5);
        chk("lu3_stall1", bus_b.stall_if_id, 1);
        tick();
        chk("lu3_cnt0", bus_b.bubble_cnt, 0);
        chk("lu3_tot6", bus_b.bubbles_total, 6);
        chk("lu3_stall0", bus_b.stall_if_id, 0);
        chk("lu3_valid0", bus_b.ex_valid, 0);
        tick();
        chk("lu3_add_ctrl", bus_b.ex_ctrl, ADD);
        chk("lu3_add_dst", bus_b.ex_dst, 4);
        chk("lu3_a_total", bus_a.bubbles_total, 2);
        idle(2);

        // no false hazards
        set_id(LW, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(ADD, 1'b1, 5'd0, 5'd0, 1'b1, 5'd2);
        #1;
        chk("nf_dst0_a", bus_a.stall_if_id, 0);
        chk("nf_dst0_b", bus_b.stall_if_id, 0);
        set_id(LW, 1'b1, 5'd0, 5'd0, 1'b0, 5'd6);
        tick();
        set_id(ADD, 1'b1, 5'd1, 5'd6, 1'b0, 5'd2);
        #1;
        chk("nf_rt_unused", bus_a.stall_if_id, 0);
        set_id(ADD, 1'b1, 5'd0, 5'd0, 1'b0, 5'd9);
        tick();
        chk("nf_add_dst", bus_a.ex_dst, 9);
        set_id(ADD, 1'b1, 5'd9, 5'd9, 1'b1, 5'd2);
        #1;
        chk("nf_nonload", bus_b.stall_if_id, 0);
        set_id(ADD, 1'b0, 5'd0, 5'd0, 1'b0, 5'd3);
        tick();
        chk("inv_ctrl", bus_a.ex_ctrl, 0);
        chk("inv_valid", bus_a.ex_valid, 0);
        chk("inv_dst", bus_a.ex_dst, 3);

        // flush mid-countdown, then hazard plus flush
        set_id(LW, 1'b1, 5'd0, 5'd0, 1'b0, 5'd7);
        tick();
        set_id(ADD, 1'b1, 5'd7, 5'd0, 1'b0, 5'd4);
        tick();
        chk("fl_pre_cnt", bus_b.bubble_cnt, 2);
        set_ctl(1'b1, 1'b0);
        #1;
        chk("fl_stall", bus_b.stall_if_id, 1);
        tick();
        chk("fl_cnt", bus_b.bubble_cnt, 0);
        chk("fl_total", bus_b.bubbles_total, 7);
        chk("fl_valid", bus_b.ex_valid, 0);
        set_ctl(1'b0, 1'b0);
        set_id(LW, 1'b1, 5'd0, 5'd0, 1'b0, 5'd8);
        tick();
        set_id(ADD, 1'b1, 5'd8, 5'd0, 1'b0, 5'd4);
        set_ctl(1'b1, 1'b0);
        #1;
        chk("hf_stall", bus_b.stall_if_id, 1);
        tick();
        chk("hf_cnt", bus_b.bubble_cnt, 0);
        chk("hf_total", bus_b.bubbles_total, 7);
        chk("hf_ctrl", bus_b.ex_ctrl, 0);
        chk("hf_a_total", bus_a.bubbles_total, 3);
        set_ctl(1'b0, 1'b0);

        // external freeze mid-countdown
        set_id(LW, 1'b1, 5'd0, 5'd0, 1'b0, 5'd7);
        tick();
        set_id(ADD, 1'b1, 5'd7, 5'd0, 1'b0, 5'd4);
        tick();
        set_ctl(1'b0, 1'b1);
        #1;
        chk("es_stall", bus_b.stall_if_id, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("es_cnt", bus_b.bubble_cnt, 2);
            chk("es_total", bus_b.bubbles_total, 8);
            chk("es_hold", bus_b.stall_if_id, 1);
        end
        set_ctl(1'b0, 1'b0);
        tick();
        chk("es_res_cnt1", bus_b.bubble_cnt, 1);
        chk("es_res_tot9", bus_b.bubbles_total, 9);
        tick();
        chk("es_res_cnt0", bus_b.bubble_cnt, 0);
        chk("es_res_tot10", bus_b.bubbles_total, 10);
        tick();
        chk("es_add_dst", bus_b.ex_dst, 4);
        chk("es_add_valid", bus_b.ex_valid, 1);

        // asynchronous reset during the second bubble
        set_id(LW, 1'b1, 5'd0, 5'd0, 1'b0, 5'd5);
        tick();
        set_id(ADD, 1'b1, 5'd5, 5'd0, 1'b0, 5'd3);
        tick();
        tick();
        chk("ar_pre_cnt", bus_b.bubble_cnt, 1);
        chk("ar_pre_total", bus_b.bubbles_total, 12);
        rst = 1'b1;
        #1;
        chk("ar_cnt", bus_b.bubble_cnt, 0);
        chk("ar_total", bus_b.bubbles_total, 0);
        chk("ar_ctrl", bus_b.ex_ctrl, 0);
        chk("ar_valid", bus_b.ex_valid, 0);
        chk("ar_dst", bus_b.ex_dst, 0);
        chk("ar_stall", bus_b.stall_if_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // saturation: back-to-back dependent loads on instance c
        set_id(LW, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5);
        prev    = '0;
        wrapped = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < 80000; i++) begin
            tick();
            if (bus_c.bubbles_total < prev) wrapped = 1'b1;
            prev = bus_c.bubbles_total;
            if (prev == 16'hFFFF) begin
                hit = 1'b1;
                break;
            end
        end
        chk("sat_reach", hit, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_c.bubbles_total < prev) wrapped = 1'b1;
            prev = bus_c.bubbles_total;
        end
        chk("sat_hold", bus_c.bubbles_total, 16'hFFFF);
        chk("sat_nowrap", wrapped, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_bubble_stage.md
# ctrl_bubble_stage

Parametrised ID/EX control pipeline stage for the pipelined processor, replacing the combinational op-gated control mux. It registers decoded control bits, destination register and valid into EX each cycle. It detects load-use hazards and inserts a programmable number of bubbles (all control bits zero) while freezing IF/ID. It also handles branch flush and an external freeze, and keeps a saturating bubble counter for performance monitoring.

## Interface
- CTRL_W, 9, width of control bundle {RegDst, RegWrite, aluSrc, MemRead, MemWrite, MemToReg, aluOp[2:0]}
- REG_AW, 5, register-address width
- MEMREAD_BIT, 5, bit index of MemRead inside the control bundle
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal 1..7
- CNT_W, 3, width of the bubble countdown; must hold LOAD_STALL
- Reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_ctrl  in  CTRL_W  decoded controls of the instruction in ID
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source registers of the ID instruction
- id_uses_rt  in  1  ID instruction reads rt
- id_dst  in  REG_AW  destination register of the ID instruction
- flush  in  1  branch taken: kill the ID instruction
- ext_stall  in  1  memory stall: freeze this stage completely
- ex_ctrl  out  CTRL_W  registered controls for EX
- ex_valid  out  1  EX holds a real instruction
- ex_dst  out  REG_AW  registered destination register
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt  out  CNT_W  remaining hazard bubbles
- bubbles_total  out  16  saturating count of hazard bubbles inserted

## Operation
- A bubble is defined as ex_ctrl=0, ex_valid=0, ex_dst=0.
- hazard = (bubble_cnt==0) & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_dst!=0) & id_valid & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).
- stall_if_id = ext_stall | hazard | (bubble_cnt!=0).
- Per-edge update, first matching rule wins:
  1. ext_stall: every register holds, including bubble_cnt and bubbles_total.
  2. flush: insert a bubble and clear bubble_cnt to 0. bubbles_total is unchanged.
  3. bubble_cnt!=0: insert a bubble, decrement bubble_cnt, increment bubbles_total.
  4. hazard: insert a bubble, load bubble_cnt with LOAD_STALL-1, increment bubbles_total.
  5. Otherwise: ex_ctrl<=id_ctrl, ex_valid<=id_valid, ex_dst<=id_dst.
- When id_valid=0, ex_ctrl is forced to 0 regardless of id_ctrl, so an invalid slot never writes.
- Effective states:
  - RUN: bubble_cnt==0.
  - STALL: bubble_cnt!=0.
  - RUN→STALL only on hazard with LOAD_STALL>1.
  - STALL→RUN when bubble_cnt decrements to 0, or on flush.
- bubbles_total saturates at 16'hFFFF and does not wrap.
- Register 0 never causes a hazard.

## Timing
- Reset: ex_ctrl=0, ex_valid=0, ex_dst=0, bubble_cnt=0, bubbles_total=0. stall_if_id then equals ext_stall.
- Reset asserted mid-STALL aborts the countdown immediately, asynchronously.
- ID→EX latency is 1 cycle. A hazard asserts stall_if_id in the same cycle it is detected.
- A hazard costs exactly LOAD_STALL cycles of IF/ID hold. The held instruction enters EX on the edge after the last bubble.
- The flush source must hold flush until ext_stall is low; a flush during ext_stall takes effect on the first unfrozen edge.
- A simultaneous hazard and flush resolves as flush: one bubble, no countdown, no count increment.

## Structure
- Shared package ctrl_pkg holds:
  - CTRL_W and the bit-index constants (including MEMREAD_BIT).
  - The NOP control constant (all zero).
  - The control bundle typedef.
- One combinational sub-module, hazard_detect, produces the hazard equation above. Counters and registers stay in ctrl_bubble_stage.

## Test plan
- Reset mid-stall: LOAD_STALL=3, rst pulse during second bubble → all outputs 0 asynchronously, bubble_cnt=0.
- Load-use, LOAD_STALL=1: EX lw with ex_dst=5; ID add with id_rs=5 → stall_if_id=1 for 1 cycle, one bubble, the add enters EX next edge, bubbles_total=1.
- Load-use, LOAD_STALL=3, rt path: id_uses_rt=1, id_rt=7=ex_dst → 3 bubbles, bubble_cnt 2,1,0, bubbles_total=3.
- No false hazards:
  - ex_dst=0 → no stall.
  - id_uses_rt=0 with id_rt matching → no stall.
  - Non-load in EX with matching ex_dst → no stall.
- Flush during STALL (bubble_cnt=2) → bubble inserted, bubble_cnt=0, count unchanged. Hazard plus flush in the same cycle → one bubble, count unchanged.
- ext_stall held 4 cycles mid-STALL → all registers frozen, stall_if_id=1. Countdown resumes afterward. Saturation check: preload count to FFFE, 3 bubbles → FFFF.
